// File: rtl/pump_valve_pwm.sv
// pump_valve_pwm: turns a signed PID command into a fixed-period PWM on either
// the inflate pump or the vent valve. Small commands inside the deadband are
// treated as idle, and a dead time separates direction reversals.
// Optional command watchdog: define PWM_WATCHDOG_EN to enable it.
module pump_valve_pwm #(
  parameter int PWM_PERIOD  = 1000,
  parameter int CMD_SHIFT   = 5,
  parameter int DEADBAND    = 50,
  parameter int DEAD_TIME   = 100
`ifdef PWM_WATCHDOG_EN
  ,
  parameter int WDT_PERIODS = 8
`endif
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic signed [15:0] cmd_i,
  input  logic               cmd_valid_i,
  output logic               pump_pwm_o,
  output logic               valve_pwm_o,
  output logic               period_start_o,
  output logic [1:0]         state_o
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int TW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DW-1:0] LAST_CNT  = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] FULL_DUTY = DW'(PWM_PERIOD);
  localparam logic [TW-1:0] LAST_DEAD = TW'(DEAD_TIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INFLATE = 2'd1,
    ST_DEFLATE = 2'd2,
    ST_DEAD    = 2'd3
  } state_e;

  state_e             state_q;
  logic [DW-1:0]      cnt_q;
  logic [DW-1:0]      duty_q;
  logic [TW-1:0]      dead_q;
  logic signed [15:0] pending_q, pending_d;
  logic               pump_q, valve_q, start_q;

  logic               boundary;
  logic               wdt_expire;
  logic signed [15:0] eval_cmd;
  logic [15:0]        mag;
  logic [15:0]        shifted;
  logic [DW-1:0]      eval_duty;
  state_e             eval_dir;

  // The last count of a running period is where direction and duty may change;
  // DEAD holds the counter at zero so it never reaches a boundary.
  assign boundary = (state_q != ST_DEAD) && (cnt_q == LAST_CNT);

`ifdef PWM_WATCHDOG_EN
  localparam int WW = (WDT_PERIODS > 1) ? $clog2(WDT_PERIODS) : 1;
  localparam logic [WW-1:0] LAST_WDT = WW'(WDT_PERIODS - 1);

  logic [WW-1:0] wdt_q, wdt_d;

  // A fresh strobe on the boundary cycle always wins over a timeout.
  assign wdt_expire = boundary && !cmd_valid_i && (wdt_q == LAST_WDT);

  // Count boundaries seen since the most recent command strobe.
  always_comb begin
    wdt_d = wdt_q;
    if (cmd_valid_i) begin
      wdt_d = '0;
    end else if (wdt_expire) begin
      wdt_d = '0;
    end else if (boundary) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  // Watchdog boundary counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_expire = 1'b0;
`endif

  // Pending command: loaded by each strobe, cleared when the watchdog fires.
  always_comb begin
    pending_d = pending_q;
    if (cmd_valid_i) begin
      pending_d = cmd_i;
    end else if (wdt_expire) begin
      pending_d = '0;
    end
  end

  // Pending command register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Direction and duty implied by the pending command; -32768 saturates so the
  // magnitude never overflows, and duty saturates at a full period.
  always_comb begin
    eval_cmd = wdt_expire ? 16'sd0 : pending_q;
    if (!eval_cmd[15]) begin
      mag = eval_cmd;
    end else if (eval_cmd == 16'sh8000) begin
      mag = 16'h7fff;
    end else begin
      mag = 16'(-eval_cmd);
    end
    shifted = mag >> CMD_SHIFT;
    if (32'(shifted) > 32'($unsigned(PWM_PERIOD))) begin
      eval_duty = FULL_DUTY;
    end else begin
      eval_duty = DW'(shifted);
    end
    if (int'(eval_cmd) > DEADBAND) begin
      eval_dir = ST_INFLATE;
    end else if (int'(eval_cmd) < -DEADBAND) begin
      eval_dir = ST_DEFLATE;
    end else begin
      eval_dir = ST_IDLE;
    end
  end

  // Direction FSM, period and dead-time counters, and registered PWM outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      dead_q  <= '0;
      pump_q  <= 1'b0;
      valve_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      pump_q  <= (state_q == ST_INFLATE) && (cnt_q < duty_q);
      valve_q <= (state_q == ST_DEFLATE) && (cnt_q < duty_q);
      start_q <= (state_q != ST_DEAD) && (cnt_q == '0);
      if (state_q == ST_DEAD) begin
        cnt_q <= '0;
        if (dead_q == LAST_DEAD) begin
          dead_q  <= '0;
          state_q <= eval_dir;
          duty_q  <= eval_duty;
        end else begin
          dead_q <= dead_q + 1'b1;
        end
      end else if (boundary) begin
        cnt_q <= '0;
        if ((state_q == ST_INFLATE && eval_dir == ST_DEFLATE) ||
            (state_q == ST_DEFLATE && eval_dir == ST_INFLATE)) begin
          state_q <= ST_DEAD;
          dead_q  <= '0;
        end else begin
          state_q <= eval_dir;
          duty_q  <= eval_duty;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pump_pwm_o     = pump_q;
  assign valve_pwm_o    = valve_q;
  assign period_start_o = start_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pump_valve_pwm.sv
// tb_pump_valve_pwm: directed vectors and multi-cycle sequences for
// pump_valve_pwm with PWM_PERIOD=100, CMD_SHIFT=0, DEADBAND=10, DEAD_TIME=8.
// Build with PWM_WATCHDOG_EN defined to exercise the 3-period watchdog.
module tb_pump_valve_pwm;

  localparam int P = 100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] cmd = '0;
  logic               cmd_valid = 1'b0;
  logic               pump, valve, pstart;
  logic [1:0]         state;

  typedef struct {
    logic signed [15:0] cmd;
    int                 pumpHigh;
    int                 valveHigh;
    int                 st;
  } vec_t;

  vec_t vecs[10];

  int cyc = -1;
  int ofs = 0;
  int tests = 0;
  int fails = 0;
  int nPump, nValve, nStart;
  int nBoth = 0;
  int wdExp[4];
  int wdState;

  pump_valve_pwm #(
    .PWM_PERIOD (P),
    .CMD_SHIFT  (0),
    .DEADBAND   (10),
    .DEAD_TIME  (8)
`ifdef PWM_WATCHDOG_EN
    ,
    .WDT_PERIODS(3)
`endif
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cmd_i         (cmd),
    .cmd_valid_i   (cmd_valid),
    .pump_pwm_o    (pump),
    .valve_pwm_o   (valve),
    .period_start_o(pstart),
    .state_o       (state)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Position of the just-sampled output within the expected period grid.
  function automatic int pos();
    return (((cyc - ofs) % P) + P) % P;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pump) nPump++;
    if (valve) nValve++;
    if (pstart) nStart++;
    if (pump && valve) nBoth++;
  endtask

  task automatic skipTo(input int p);
    for (int i = 0; i < P && pos() != p; i++) tick();
  endtask

  task automatic clearCounts();
    nPump = 0;
    nValve = 0;
    nStart = 0;
  endtask

  task automatic measure();
    clearCounts();
    repeat (P) tick();
  endtask

  task automatic applyStimulus(input logic signed [15:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{16'sd40,     40,  0, 1};
    vecs[1] = '{16'sd500,   100,  0, 1};
    vecs[2] = '{16'sd10,      0,  0, 0};
    vecs[3] = '{-16'sd32768,  0, 100, 2};
    vecs[4] = '{-16'sd10,     0,  0, 0};
    vecs[5] = '{-16'sd11,     0, 11, 2};
    vecs[6] = '{16'sd0,       0,  0, 0};
    vecs[7] = '{16'sd25,     25,  0, 1};
    vecs[8] = '{16'sd100,   100,  0, 1};
    vecs[9] = '{16'sd99,     99,  0, 1};
`ifdef PWM_WATCHDOG_EN
    wdExp = '{40, 40, 0, 0};
    wdState = 0;
`else
    wdExp = '{40, 40, 40, 40};
    wdState = 1;
`endif

    // Reset asserted mid-period while a +60 command is driving the pump.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    skipTo(50);
    applyStimulus(16'sd60);
    skipTo(99);
    repeat (20) tick();
    checkOutput("pre-reset pump", int'(pump), 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset pump", int'(pump), 0);
    checkOutput("reset valve", int'(valve), 0);
    checkOutput("reset start", int'(pstart), 0);
    checkOutput("reset state", int'(state), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    ofs = 0;
    clearCounts();
    repeat (250) tick();
    checkOutput("post-reset pump cycles", nPump, 0);
    checkOutput("post-reset valve cycles", nValve, 0);
    checkOutput("post-reset period starts", nStart, 3);
    checkOutput("post-reset state", int'(state), 0);

    // Steady-state duty, deadband and saturation vectors.
    for (int i = 0; i < 10; i++) begin
      skipTo(50);
      applyStimulus(vecs[i].cmd);
      skipTo(99);
      checkOutput($sformatf("vec%0d state", i), int'(state), vecs[i].st);
      measure();
      checkOutput($sformatf("vec%0d pump cycles", i), nPump, vecs[i].pumpHigh);
      checkOutput($sformatf("vec%0d valve cycles", i), nValve, vecs[i].valveHigh);
      checkOutput($sformatf("vec%0d period starts", i), nStart, 1);
    end

    // Strobe on the boundary cycle: old duty holds for one more period.
    skipTo(50);
    applyStimulus(16'sd40);
    skipTo(98);
    applyStimulus(16'sd70);
    measure();
    checkOutput("boundary strobe old duty", nPump, 40);
    measure();
    checkOutput("boundary strobe new duty", nPump, 70);

    // Two strobes in one period: only the later one takes effect.
    skipTo(30);
    applyStimulus(16'sd20);
    skipTo(60);
    applyStimulus(16'sd55);
    skipTo(99);
    measure();
    checkOutput("double strobe duty", nPump, 55);

    // Inflate to deflate reversal through the dead time.
    skipTo(50);
    applyStimulus(16'sd40);
    skipTo(99);
    checkOutput("reversal pre state", int'(state), 1);
    clearCounts();
    skipTo(50);
    applyStimulus(-16'sd30);
    skipTo(99);
    checkOutput("reversal last pump period", nPump, 40);
    checkOutput("reversal dead state entry", int'(state), 3);
    begin
      int deadSeen = 0;
      clearCounts();
      for (int i = 0; i < 8; i++) begin
        if (state == 2'd3) deadSeen++;
        tick();
      end
      checkOutput("dead state cycles", deadSeen, 8);
    end
    checkOutput("dead outputs low", nPump + nValve, 0);
    checkOutput("dead no period start", nStart, 0);
    checkOutput("post-dead state", int'(state), 2);
    clearCounts();
    tick();
    ofs = cyc % P;
    checkOutput("first valve cycle", int'(valve), 1);
    checkOutput("first period start after dead", int'(pstart), 1);
    repeat (P - 1) tick();
    checkOutput("reversal valve cycles", nValve, 30);
    checkOutput("reversal pump cycles", nPump, 0);
    checkOutput("reversal period starts", nStart, 1);

    // Single strobe, then silence: watchdog behaviour depends on the build.
    skipTo(50);
    applyStimulus(16'sd0);
    skipTo(99);
    skipTo(50);
    applyStimulus(16'sd40);
    skipTo(99);
    checkOutput("watchdog start state", int'(state), 1);
    for (int k = 0; k < 4; k++) begin
      measure();
      checkOutput($sformatf("watchdog period%0d pump cycles", k), nPump, wdExp[k]);
      if (k == 1) checkOutput("watchdog state after 3 boundaries", int'(state), wdState);
    end

    checkOutput("pump and valve overlap cycles", nBoth, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pump_valve_pwm.md
# pump_valve_pwm

Actuator driver at the output end of the gripper pressure loop. Consumes each signed 16-bit PID command, picks the inflate (pump) or deflate (vent valve) direction, and converts the command magnitude into a fixed-period PWM on the selected actuator. The other actuator is held off. The block enforces a deadband around zero and a dead time between direction reversals, so pump and valve are never driven together.

## Interface
- `PWM_PERIOD`, 1000: PWM period in CLK cycles (≥2).
- `CMD_SHIFT`, 5: right shift applied to the command magnitude to form duty counts.
- `DEADBAND`, 50: |cmd| ≤ DEADBAND is treated as zero (idle).
- `DEAD_TIME`, 100: cycles both outputs are forced low on a direction reversal (≥1).
- `WDT_PERIODS`, 8: watchdog timeout in PWM periods (only with the watchdog macro).
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RESET_N` in 1: one clock; reset is asynchronous and active-low.
- `CMD` in 16: signed PID command. Positive means inflate; negative means deflate.
- `CMD_VALID` in 1: one-cycle strobe marking a new `CMD`.
- `PUMP_PWM` out 1: inflate actuator drive. Registered.
- `VALVE_PWM` out 1: deflate actuator drive. Registered.
- `PERIOD_START` out 1: one-cycle pulse on the first output cycle of each PWM period. Registered.
- `STATE` out 2: 0 IDLE, 1 INFLATE, 2 DEFLATE, 3 DEAD.

## Operation
- **Command capture**
  - `CMD_VALID` loads `CMD` into the pending register.
  - The pending value is used only at period boundaries; mid-period commands never change the current period.
- **Magnitude**
  - mag = |pending|, with -32768 saturated to 32767.
  - duty = min(mag >> CMD_SHIFT, PWM_PERIOD).
- **Desired direction**
  - pending > DEADBAND: INFLATE.
  - pending < -DEADBAND: DEFLATE.
  - Otherwise: IDLE.
- **Period counter**
  - cnt counts 0..PWM_PERIOD-1 and wraps.
  - The cycle with cnt = PWM_PERIOD-1 is the boundary. State and duty update on the edge leaving it.
- **FSM at each boundary**
  - IDLE→INFLATE/DEFLATE: direct.
  - Any state→IDLE: direct.
  - Same direction: stay, with duty refreshed.
  - INFLATE↔DEFLATE: go to DEAD.
- **DEAD state**
  - Both outputs are low and cnt is held at 0.
  - The dead counter runs DEAD_TIME cycles. On expiry, the direction and duty are re-evaluated from pending at that cycle and the FSM enters that state directly.
  - The period restarts at cnt = 0. A return to the original direction is allowed.
- **Outputs**
  - PUMP_PWM = (state==INFLATE && cnt<duty).
  - VALVE_PWM = (state==DEFLATE && cnt<duty).
  - Both are registered one cycle behind cnt/state.
  - duty = 0 gives a constant low; duty = PWM_PERIOD gives a constant high for the whole period.
  - PUMP_PWM and VALVE_PWM are never both high.
- **Reset**
  - Asynchronous assertion: PUMP_PWM = 0, VALVE_PWM = 0, PERIOD_START = 0, STATE = IDLE.
  - cnt, the dead counter and pending are cleared immediately, including mid-period and mid-DEAD.
  - First period after release: cnt counts from 0 and the first boundary evaluates pending = 0, giving IDLE.

## Timing
- **Command latency:** `CMD_VALID` at cycle t updates pending at t+1 and takes effect at the next boundary. Output changes appear one cycle after the boundary edge.
- **CMD_VALID on the boundary cycle:** the boundary uses the old pending value; the new value applies at the following boundary.
- **Reversal:** the last active output cycle is followed by exactly DEAD_TIME cycles with both outputs low, then the first cycle of the new direction (registered lag included).
- **PERIOD_START:** one cycle wide. It is aligned with the first output cycle of every period, including the first period after DEAD. It does not pulse during DEAD or reset.

## Configuration
- **`PWM_WATCHDOG_EN` defined:**
  - A period counter clears on every `CMD_VALID`.
  - If WDT_PERIODS boundaries pass with no `CMD_VALID`, pending is forced to 0 at that boundary, so the block goes to IDLE and both outputs go low.
  - A later `CMD_VALID` resumes normal operation.
- **Not defined:** no watchdog logic. The last pending command is held indefinitely.

## Test plan
Bench parameters: PWM_PERIOD=100, CMD_SHIFT=0, DEADBAND=10, DEAD_TIME=8, WDT_PERIODS=3.

- **Reset:** RESET_N low mid-period with CMD=+60 active → all outputs 0 and STATE=0 immediately; after release they stay 0 until a new CMD.
- **Inflate duty:** CMD=+40 → from the next period, PUMP_PWM high exactly 40 of every 100 cycles, VALVE_PWM 0, PERIOD_START every 100 cycles.
- **Deadband and saturation:**
  - CMD=+10 or -10 → IDLE, both outputs 0.
  - CMD=+500 → PUMP_PWM constant high.
  - CMD=-32768 → VALVE_PWM constant high, with no overflow.
- **Reversal:** CMD=+40 then CMD=-30 mid-period → the current pump period completes, 8 cycles with both outputs low (STATE=3), then VALVE_PWM high 30 of 100 cycles; both outputs never high in the same cycle.
- **Command timing:**
  - CMD_VALID on the boundary cycle with a new value → the old duty is kept for one more period.
  - Two CMD_VALIDs in one period → only the last applies.
- **Watchdog (PWM_WATCHDOG_EN defined):** CMD=+40 once and no further strobes → PUMP_PWM stops after 3 boundaries, STATE=0. Rerun with the macro undefined → PUMP_PWM continues indefinitely.
